// File: rtl/shifter_pkg.sv
// Shared types for the sequential shifter: shift mode encoding, FSM states
// and the shift-amount width helper.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10,
        MODE_SRL = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single combinational shift of 0..STEP bits in any of the four modes.
module shift_step
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 4,
    localparam int AMT_W = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] data_out
);

    // A rotate by zero degenerates cleanly: shifting left by WIDTH yields 0.
    always_comb begin
        data_out = data_in;
        case (mode)
            MODE_SLL: data_out = data_in << amt;
            MODE_SRA: data_out = $unsigned($signed(data_in) >>> amt);
            MODE_ROR: data_out = (data_in >> amt) | (data_in << (WIDTH - int'(amt)));
            MODE_SRL: data_out = data_in >> amt;
            default:  data_out = data_in;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter: applies at most STEP bits of shift per cycle
// until the captured shift amount is consumed, then holds the result.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int STEP    = 4,
    localparam int SHAMT_W = shamt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    localparam int AMT_W = $clog2(STEP) + 1;

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    shift_mode_e        mode_q, mode_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   step_out;
    logic [AMT_W-1:0]   amt;

    always_comb begin
        amt = AMT_W'(STEP);
        if (int'(rem_q) < STEP) begin
            amt = AMT_W'(rem_q);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_in  (data_q),
        .amt      (amt),
        .mode     (mode_q),
        .data_out (step_out)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = in_shamt;
                    mode_d  = shift_mode_e'(in_mode);
                    state_d = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                data_d = step_out;
                rem_d  = rem_q - SHAMT_W'(amt);
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Returning to IDLE here means no accept can share this edge.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= MODE_SLL;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=16, STEP=4): directed cases plus
// randomized back-to-back traffic against a cycle-count reference model.
module tb_seq_shifter;

    localparam int P_IDLE  = 0;
    localparam int P_SHIFT = 1;
    localparam int P_DONE  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_shamt = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    bit          drv_done = 1'b0;

    int          m_phase = P_IDLE;
    int          m_left = 0;
    logic [15:0] m_result = '0;
    int          n_acc = 0;
    int          n_out = 0;
    int          n_disc = 0;

    seq_shifter #(
        .WIDTH (16),
        .STEP  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int s,
                                              input logic [1:0] m);
        case (m)
            2'b00:   return d << s;
            2'b01:   return 16'($signed(d) >>> s);
            2'b10:   return (d >> s) | (d << (16 - s));
            default: return d >> s;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are only driven just after a rising edge, so the falling edge
    // sees exactly what the next rising edge will sample.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(m_phase == P_IDLE));
            check("out_valid", 32'(out_valid), 32'(m_phase == P_DONE));
            check("busy", 32'(busy), 32'(m_phase != P_IDLE));
            if (m_phase != P_SHIFT) check("out_data", 32'(out_data), 32'(m_result));
        end
        if (rst) begin
            if (m_phase != P_IDLE) n_disc++;
            m_phase  = P_IDLE;
            m_result = '0;
        end else begin
            case (m_phase)
                P_IDLE: if (in_valid) begin
                    m_result = ref_shift(in_data, int'(in_shamt), in_mode);
                    m_left   = (int'(in_shamt) + 3) / 4;
                    m_phase  = (m_left == 0) ? P_DONE : P_SHIFT;
                    n_acc++;
                end
                P_SHIFT: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_DONE;
                end
                default: if (out_ready) begin
                    n_out++;
                    m_phase = P_IDLE;
                end
            endcase
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        tick();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_shamt = 4'($urandom);
        in_mode  = 2'($urandom);
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            in_shamt = 4'($urandom);
            in_mode  = 2'($urandom);
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] exp_data, input int exp_lat);
        int lat;
        waitValid(lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_data"}, 32'(out_data), 32'(exp_data));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int acc0;
        int out0;
        int guard;

        check("model_sra", 32'(ref_shift(16'h8000, 15, 2'b01)), 32'h0000FFFF);
        check("model_ror", 32'(ref_shift(16'h1234, 4, 2'b10)), 32'h00004123);
        check("model_srl", 32'(ref_shift(16'h8000, 15, 2'b11)), 32'h00000001);

        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        chk_en = 1'b1;

        applyStimulus(16'h8000, 4'd15, 2'b01);
        checkOutput("sra_8000_15", 16'hFFFF, 5);
        applyStimulus(16'h1234, 4'd4, 2'b10);
        checkOutput("ror_1234_4", 16'h4123, 2);
        applyStimulus(16'h8000, 4'd15, 2'b11);
        checkOutput("srl_8000_15", 16'h0001, 5);
        applyStimulus(16'h00FF, 4'd0, 2'b00);
        checkOutput("sll_00ff_0", 16'h00FF, 1);
        check("idle_holds_result", 32'(out_data), 32'h00FF);

        applyStimulus(16'h0001, 4'd9, 2'b00);
        waitValid(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hABCD;
            in_shamt = 4'd3;
            in_mode  = 2'b11;
            tick();
            check("bp_data_stable", 32'(out_data), 32'h0200);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_release_idle", 32'(in_ready), 32'd1);
        tick();
        check("bp_second_ignored", 32'(in_ready), 32'd1);
        check("bp_no_result", 32'(out_valid), 32'd0);

        applyStimulus(16'hF000, 4'd12, 2'b01);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_rst_no_emit", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        acc0 = n_acc;
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    in_valid = 1'b1;
                    in_data  = 16'($urandom);
                    in_shamt = 4'($urandom_range(0, 15));
                    in_mode  = 2'($urandom);
                    guard = 0;
                    while (!in_ready && guard < 200) begin
                        tick();
                        guard++;
                    end
                    if (!in_ready) begin
                        check("rand_accept_timeout", 32'd0, 32'd1);
                        break;
                    end
                    tick();
                end
                in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    tick();
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        guard = 0;
        while (busy && guard < 50) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        check("rand_drained", 32'(busy), 32'd0);
        check("rand_accepted", 32'(n_acc - acc0), 32'd200);
        check("rand_delivered", 32'(n_out - out0), 32'd200);
        check("discarded_total", 32'(n_disc), 32'd1);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits, SHALL be a power of two and at least 4.
REQ-002 Parameter STEP, default 4: maximum shift distance applied per cycle, SHALL be a power of two with 1 <= STEP <= WIDTH.
REQ-003 Derived constant SHAMT_W = clog2(WIDTH): width of the shift amount; it SHALL NOT be overridable.
REQ-004 Ports SHALL be exactly as listed, with one clock; reset is synchronous and active-high:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  request present
  in_ready  out  1  block can accept a request
  in_data  in  WIDTH  operand
  in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1
  in_mode  in  2  00 SLL, 01 SRA, 10 ROR, 11 SRL
  out_valid  out  1  result present
  out_ready  in  1  consumer accepts result
  out_data  out  WIDTH  result
  busy  out  1  request in flight (SHIFT or DONE state)

Function
REQ-005 An FSM SHALL have the states IDLE, SHIFT and DONE; in_ready SHALL equal (state==IDLE), out_valid SHALL equal (state==DONE), and busy SHALL equal (state!=IDLE).
REQ-006 Accept: at a rising edge with in_valid and in_ready both high, the block SHALL capture in_data, in_shamt and in_mode, and SHALL load the remaining count with in_shamt.
REQ-007 If the captured shamt is 0, the next state SHALL be DONE with out_data = in_data, for every mode.
REQ-008 If the captured shamt is not 0, the next state SHALL be SHIFT.
REQ-009 In each SHIFT cycle:
  - amt = min(remaining, STEP);
  - the working register SHALL be shifted by amt in the captured mode;
  - remaining SHALL be reduced by amt;
  - the next state SHALL be DONE when remaining reaches 0, and SHIFT otherwise.
REQ-010 Mode semantics:
  - SLL: fill with 0 at the LSB.
  - SRA: replicate the original MSB.
  - SRL: fill with 0 at the MSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
REQ-011 Latency: out_valid SHALL rise exactly ceil(shamt/STEP)+1 cycles after the accept edge.
REQ-012 In DONE, out_data SHALL hold stable until an edge with out_ready high, after which the state SHALL become IDLE; a new request SHALL NOT be accepted in that same edge.
REQ-013 Throughput: at most one request in flight; in_valid seen while busy SHALL be ignored and SHALL NOT be captured.
REQ-014 out_data SHALL retain the last result in IDLE and SHALL change only during SHIFT or at accept.
REQ-015 Mode and shamt changes on the inputs during SHIFT or DONE SHALL NOT affect the in-flight result.

Reset
REQ-016 While rst is high at a clock edge: state SHALL become IDLE, remaining 0, out_data 0, and the captured mode 00.
REQ-017 Outputs after reset: in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-018 Reset during SHIFT or DONE SHALL discard the in-flight request without producing an out_valid pulse.
REQ-019 rst SHALL take priority over an in/out handshake in the same cycle.

Structure
REQ-020 A shared package shifter_pkg SHALL hold the mode encoding (SLL, SRA, ROR, SRL), the FSM state encoding, and the SHAMT_W helper function.
REQ-021 A combinational sub-module shift_step (WIDTH, STEP) SHALL perform a single shift of 0..STEP bits for any mode; seq_shifter SHALL instantiate it once.
REQ-022 The implementation SHALL NOT use the variable-amount shift operator on the full shamt.

Verification (WIDTH=16, STEP=4)
REQ-023 SRA 0x8000, shamt 15 -> 0xFFFF; out_valid 5 cycles after accept (shift steps 4,4,4,3).
REQ-024 ROR 0x1234, shamt 4 -> 0x4123 after 2 cycles; SRL 0x8000, shamt 15 -> 0x0001; SLL 0x00FF, shamt 0 -> 0x00FF after 1 cycle.
REQ-025 Backpressure: SLL 0x0001, shamt 9 -> 0x0200; hold out_ready=0 for 3 cycles -> out_data stable, in_ready=0, and a second in_valid is ignored.
REQ-026 Assert rst in the 2nd SHIFT cycle of SRA 0xF000, shamt 12 -> next cycle in_ready=1, out_valid=0, out_data=0; no result is emitted.
REQ-027 Back-to-back traffic: 200 random requests with random out_ready -> every result matches the reference model, and no request is lost or duplicated.
